// File: rtl/boron_stream_ctrl.sv
// BORON multi-block sequencer: key schedule, per-block core launch with in/out
// handshakes, CBC IV select and a watchdog on key schedule and core completion.
module boron_stream_ctrl #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TO_W    = 7,
   parameter int unsigned TIMEOUT = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             enc_dec,
   input  logic             cbc_en,
   input  logic             key_reuse,
   input  logic [CNT_W-1:0] num_blocks,
   input  logic             keyDone,
   input  logic             encdecDone,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             keyStart,
   output logic             encStart,
   output logic             decStart,
   output logic             iv_sel,
   output logic             in_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] blk_idx,
   output logic             busy,
   output logic             done,
   output logic             error
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_KEYGEN   = 3'd1,
      S_WAIT_IN  = 3'd2,
      S_CORE     = 3'd3,
      S_WAIT_OUT = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic             enc_q;
   logic             cbc_q;
   logic [CNT_W-1:0] num_q;
   logic             key_valid;
   logic [TO_W-1:0]  wd_q;

   logic             key_start_d;
   logic             enc_start_d;
   logic             dec_start_d;
   logic             iv_sel_d;
   logic             in_ready_d;
   logic             out_valid_d;
   logic [CNT_W-1:0] blk_idx_d;
   logic             busy_d;
   logic             done_d;
   logic             error_d;
   logic             key_valid_d;
   logic [TO_W-1:0]  wd_d;

   logic             accept;
   logic             zero_job;
   logic             use_key;
   logic             last_blk;
   logic             out_hs;
   logic             wd_hit;
   logic             timeout;

   // Shared decode; a completion in the final watchdog cycle beats the timeout.
   always_comb begin
      accept   = (state_q == S_IDLE) && start;
      zero_job = (num_blocks == '0);
      use_key  = key_reuse && key_valid;
      last_blk = (blk_idx == (num_q - CNT_W'(1)));
      out_hs   = (state_q == S_WAIT_OUT) && out_ready;
      wd_hit   = (wd_q == TO_W'(TIMEOUT - 1));
      timeout  = wd_hit && (((state_q == S_KEYGEN) && !keyDone) ||
                            ((state_q == S_CORE)   && !encdecDone));
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && !zero_job) state_d = use_key ? S_WAIT_IN : S_KEYGEN;
         end
         S_KEYGEN: begin
            if (keyDone)      state_d = S_WAIT_IN;
            else if (timeout) state_d = S_IDLE;
         end
         S_WAIT_IN: begin
            if (in_valid) state_d = S_CORE;
         end
         S_CORE: begin
            if (encdecDone)   state_d = S_WAIT_OUT;
            else if (timeout) state_d = S_IDLE;
         end
         S_WAIT_OUT: begin
            if (out_ready) state_d = last_blk ? S_IDLE : S_WAIT_IN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values, all captured in the register below
   always_comb begin
      key_start_d = 1'b0;
      enc_start_d = 1'b0;
      dec_start_d = 1'b0;
      iv_sel_d    = 1'b0;
      in_ready_d  = (state_d == S_WAIT_IN);
      out_valid_d = (state_d == S_WAIT_OUT);
      busy_d      = (state_d != S_IDLE);
      done_d      = 1'b0;
      error_d     = error;
      key_valid_d = key_valid;
      blk_idx_d   = blk_idx;
      wd_d        = wd_q;

      if (accept) begin
         error_d     = 1'b0;
         blk_idx_d   = '0;
         key_start_d = !zero_job && !use_key;
         done_d      = zero_job;
      end

      if ((state_q == S_KEYGEN) && keyDone) key_valid_d = 1'b1;

      if ((state_q == S_WAIT_IN) && in_valid) begin
         enc_start_d = enc_q;
         dec_start_d = !enc_q;
         iv_sel_d    = cbc_q && (blk_idx == '0);
      end

      if (out_hs) begin
         if (last_blk) done_d = 1'b1;
         else          blk_idx_d = blk_idx + CNT_W'(1);
      end

      if (timeout) begin
         error_d     = 1'b1;
         done_d      = 1'b1;
         key_valid_d = 1'b0;
      end

      // Counter restarts on every state change so each KEYGEN/CORE visit starts at 0
      if (state_d != state_q)
         wd_d = '0;
      else if ((state_q == S_KEYGEN) || (state_q == S_CORE))
         wd_d = wd_q + TO_W'(1);
   end

   // Output and job-context registers
   always_ff @(posedge clk) begin
      if (reset) begin
         keyStart  <= 1'b0;
         encStart  <= 1'b0;
         decStart  <= 1'b0;
         iv_sel    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         blk_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         key_valid <= 1'b0;
         wd_q      <= '0;
         enc_q     <= 1'b0;
         cbc_q     <= 1'b0;
         num_q     <= '0;
      end else begin
         keyStart  <= key_start_d;
         encStart  <= enc_start_d;
         decStart  <= dec_start_d;
         iv_sel    <= iv_sel_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         blk_idx   <= blk_idx_d;
         busy      <= busy_d;
         done      <= done_d;
         error     <= error_d;
         key_valid <= key_valid_d;
         wd_q      <= wd_d;
         if (accept) begin
            enc_q <= enc_dec;
            cbc_q <= cbc_en;
            num_q <= num_blocks;
         end
      end
   end

endmodule

// File: tb/tb_boron_stream_ctrl.sv
// Directed bench for boron_stream_ctrl: a small key/core responder model plus
// per-scenario tasks with hand-computed expectations.
module tb_boron_stream_ctrl;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned TO_W    = 7;
   localparam int unsigned TIMEOUT = 100;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             enc_dec = 1'b0;
   logic             cbc_en = 1'b0;
   logic             key_reuse = 1'b0;
   logic [CNT_W-1:0] num_blocks = '0;
   logic             key_done = 1'b0;
   logic             encdec_done = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             key_start, enc_start, dec_start, iv_sel;
   logic             in_ready, out_valid, busy, done, error;
   logic [CNT_W-1:0] blk_idx;

   int tests = 0;
   int fails = 0;

   boron_stream_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .enc_dec(enc_dec), .cbc_en(cbc_en),
      .key_reuse(key_reuse), .num_blocks(num_blocks), .keyDone(key_done),
      .encdecDone(encdec_done), .in_valid(in_valid), .out_ready(out_ready),
      .keyStart(key_start), .encStart(enc_start), .decStart(dec_start),
      .iv_sel(iv_sel), .in_ready(in_ready), .out_valid(out_valid),
      .blk_idx(blk_idx), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Responder and event log, evaluated mid-cycle while DUT outputs are stable
   int n_key = 0, n_enc = 0, n_dec = 0, n_done = 0;
   int key_lat = 5, core_lat = 4;
   int kcnt = 0, ccnt = 0;
   bit iv_q[$];
   int bi_q[$];

   always @(negedge clk) begin
      if (key_start) n_key++;
      if (enc_start) n_enc++;
      if (dec_start) n_dec++;
      if (done)      n_done++;
      if (enc_start || dec_start) begin
         iv_q.push_back(iv_sel);
         bi_q.push_back(int'(blk_idx));
      end
      key_done    = 1'b0;
      encdec_done = 1'b0;
      if (key_start) kcnt = key_lat;
      else if (kcnt > 0) begin
         kcnt--;
         if (kcnt == 0) key_done = 1'b1;
      end
      if (enc_start || dec_start) ccnt = core_lat;
      else if (ccnt > 0) begin
         ccnt--;
         if (ccnt == 0) encdec_done = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input bit ed, input bit cbc, input bit reuse, input int nb);
      enc_dec    = ed;
      cbc_en     = cbc;
      key_reuse  = reuse;
      num_blocks = CNT_W'(nb);
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = -1;
      for (int i = 0; i < max; i++) begin
         if (done) begin
            cyc = i;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      tests++; if ({key_start, enc_start, dec_start, iv_sel} !== 4'b0) begin fails++; $display("FAIL reset_pulses got %b want 0000", {key_start, enc_start, dec_start, iv_sel}); end
      tests++; if ({in_ready, out_valid} !== 2'b0) begin fails++; $display("FAIL reset_handshake got %b want 00", {in_ready, out_valid}); end
      tests++; if (blk_idx !== 8'd0) begin fails++; $display("FAIL reset_blk_idx got %0d want 0", blk_idx); end
      tests++; if ({busy, done, error} !== 3'b0) begin fails++; $display("FAIL reset_status got %b want 000", {busy, done, error}); end
      reset = 1'b0;
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_enc_cbc();
      int k0, e0, d0, dn0, i0, c;
      bit exp_iv[3];
      k0 = n_key; e0 = n_enc; d0 = n_dec; dn0 = n_done; i0 = iv_q.size();
      exp_iv = '{1'b1, 1'b0, 1'b0};
      in_valid = 1'b1; out_ready = 1'b1;
      launch(1'b1, 1'b1, 1'b0, 3);
      tests++; if (key_start !== 1'b1) begin fails++; $display("FAIL enc_keystart got %b want 1", key_start); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL enc_busy got %b want 1", busy); end
      step();
      tests++; if (key_start !== 1'b0) begin fails++; $display("FAIL enc_keystart_width got %b want 0", key_start); end
      wait_done(300, c);
      tests++; if (c < 0) begin fails++; $display("FAIL enc_done_timeout got %0d want >=0", c); end
      tests++; if (error !== 1'b0) begin fails++; $display("FAIL enc_error got %b want 0", error); end
      step();
      tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL enc_after_done got %b want 00", {done, busy}); end
      tests++; if (n_key - k0 !== 1) begin fails++; $display("FAIL enc_keystart_count got %0d want 1", n_key - k0); end
      tests++; if (n_enc - e0 !== 3) begin fails++; $display("FAIL enc_encstart_count got %0d want 3", n_enc - e0); end
      tests++; if (n_dec - d0 !== 0) begin fails++; $display("FAIL enc_decstart_count got %0d want 0", n_dec - d0); end
      tests++; if (n_done - dn0 !== 1) begin fails++; $display("FAIL enc_done_count got %0d want 1", n_done - dn0); end
      tests++;
      if (iv_q.size() - i0 !== 3) begin
         fails++; $display("FAIL enc_start_log got %0d want 3", iv_q.size() - i0);
      end else begin
         for (int j = 0; j < 3; j++) begin
            tests++; if (iv_q[i0+j] !== exp_iv[j]) begin fails++; $display("FAIL enc_iv_sel[%0d] got %b want %b", j, iv_q[i0+j], exp_iv[j]); end
            tests++; if (bi_q[i0+j] !== j) begin fails++; $display("FAIL enc_blk_idx[%0d] got %0d want %0d", j, bi_q[i0+j], j); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int k0, e0, d0, i0, c;
      k0 = n_key; e0 = n_enc; d0 = n_dec; i0 = iv_q.size();
      launch(1'b0, 1'b0, 1'b1, 2);
      tests++; if (key_start !== 1'b0) begin fails++; $display("FAIL reuse_keystart got %b want 0", key_start); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reuse_in_ready got %b want 1", in_ready); end
      wait_done(300, c);
      tests++; if (c < 0) begin fails++; $display("FAIL reuse_done_timeout got %0d want >=0", c); end
      step();
      tests++; if (n_key - k0 !== 0) begin fails++; $display("FAIL reuse_keystart_count got %0d want 0", n_key - k0); end
      tests++; if (n_dec - d0 !== 2) begin fails++; $display("FAIL reuse_decstart_count got %0d want 2", n_dec - d0); end
      tests++; if (n_enc - e0 !== 0) begin fails++; $display("FAIL reuse_encstart_count got %0d want 0", n_enc - e0); end
      tests++;
      if (iv_q.size() - i0 !== 2) begin
         fails++; $display("FAIL reuse_start_log got %0d want 2", iv_q.size() - i0);
      end else begin
         for (int j = 0; j < 2; j++) begin
            tests++; if (iv_q[i0+j] !== 1'b0) begin fails++; $display("FAIL reuse_iv_sel[%0d] got %b want 0", j, iv_q[i0+j]); end
         end
      end
   endtask

   task automatic test_backpressure();
      int e0, c;
      bit seen;
      e0 = n_enc; seen = 1'b0;
      out_ready = 1'b0;
      launch(1'b1, 1'b0, 1'b1, 2);
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin seen = 1'b1; break; end
         step();
      end
      tests++; if (seen !== 1'b1) begin fails++; $display("FAIL bp_out_valid_seen got %b want 1", seen); end
      for (int i = 0; i < 10; i++) begin
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_hold[%0d] got %b want 1", i, out_valid); end
         tests++; if (blk_idx !== 8'd0) begin fails++; $display("FAIL bp_blk_idx[%0d] got %0d want 0", i, blk_idx); end
         tests++; if (n_enc - e0 !== 1) begin fails++; $display("FAIL bp_no_start[%0d] got %0d want 1", i, n_enc - e0); end
         step();
      end
      out_ready = 1'b1;
      step();
      tests++; if (blk_idx !== 8'd1) begin fails++; $display("FAIL bp_blk_advance got %0d want 1", blk_idx); end
      wait_done(300, c);
      tests++; if (c < 0) begin fails++; $display("FAIL bp_done_timeout got %0d want >=0", c); end
      step();
      tests++; if (n_enc - e0 !== 2) begin fails++; $display("FAIL bp_encstart_count got %0d want 2", n_enc - e0); end
   endtask

   task automatic test_watchdog();
      int cyc, c;
      key_lat = 0;
      launch(1'b1, 1'b0, 1'b0, 1);
      tests++; if (key_start !== 1'b1) begin fails++; $display("FAIL wd_keystart got %b want 1", key_start); end
      cyc = -1;
      for (int n = 1; n <= 130; n++) begin
         step();
         if (done) begin cyc = n; break; end
      end
      tests++; if (cyc !== 100) begin fails++; $display("FAIL wd_done_cycle got %0d want 100", cyc); end
      tests++; if ({error, busy} !== 2'b10) begin fails++; $display("FAIL wd_error_busy got %b want 10", {error, busy}); end
      step();
      tests++; if ({error, done} !== 2'b10) begin fails++; $display("FAIL wd_error_sticky got %b want 10", {error, done}); end
      key_lat = 5;
      launch(1'b1, 1'b0, 1'b1, 1);
      tests++; if (key_start !== 1'b1) begin fails++; $display("FAIL wd_key_invalidated got %b want 1", key_start); end
      tests++; if (error !== 1'b0) begin fails++; $display("FAIL wd_error_clear got %b want 0", error); end
      wait_done(300, c);
      tests++; if (c < 0) begin fails++; $display("FAIL wd_recover_done got %0d want >=0", c); end
      step();
   endtask

   task automatic test_zero_blocks();
      int k0, e0, d0;
      k0 = n_key; e0 = n_enc; d0 = n_dec;
      launch(1'b1, 1'b1, 1'b0, 0);
      tests++; if ({done, busy, key_start} !== 3'b100) begin fails++; $display("FAIL zero_done_pulse got %b want 100", {done, busy, key_start}); end
      step();
      tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL zero_after got %b want 00", {done, busy}); end
      step();
      tests++; if ((n_key - k0) + (n_enc - e0) + (n_dec - d0) !== 0) begin fails++; $display("FAIL zero_no_starts got %0d want 0", (n_key - k0) + (n_enc - e0) + (n_dec - d0)); end
   endtask

   task automatic test_reset_mid_job();
      int i0, dn0, c;
      bit seen;
      i0 = bi_q.size(); seen = 1'b0;
      launch(1'b1, 1'b0, 1'b1, 4);
      for (int i = 0; i < 200; i++) begin
         step();
         if (bi_q.size() > i0 + 1) begin seen = 1'b1; break; end
      end
      tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rst_block1_seen got %b want 1", seen); end
      tests++; if (blk_idx !== 8'd1) begin fails++; $display("FAIL rst_in_block1 got %0d want 1", blk_idx); end
      reset = 1'b1;
      dn0 = n_done;
      step();
      reset = 1'b0;
      tests++; if ({key_start, enc_start, dec_start, iv_sel, in_ready, out_valid, busy, done, error} !== 9'b0) begin
         fails++; $display("FAIL rst_outputs got %b want 0", {key_start, enc_start, dec_start, iv_sel, in_ready, out_valid, busy, done, error});
      end
      tests++; if (blk_idx !== 8'd0) begin fails++; $display("FAIL rst_blk_idx got %0d want 0", blk_idx); end
      for (int i = 0; i < 6; i++) step();
      tests++; if (n_done - dn0 !== 0) begin fails++; $display("FAIL rst_no_done got %0d want 0", n_done - dn0); end
      launch(1'b1, 1'b0, 1'b1, 1);
      tests++; if (key_start !== 1'b1) begin fails++; $display("FAIL rst_key_invalidated got %b want 1", key_start); end
      wait_done(300, c);
      tests++; if (c < 0) begin fails++; $display("FAIL rst_recover_done got %0d want >=0", c); end
      step();
   endtask

   initial begin
      test_reset();
      test_enc_cbc();
      test_back_to_back();
      test_backpressure();
      test_watchdog();
      test_zero_blocks();
      test_reset_mid_job();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
